// File: rtl/lfsr.sv
// Runtime-configurable Fibonacci LFSR, one sequence bit per clock (x1/x2 generators of the NR Gold sequence).
// Optional build macro LFSR_STATE_OUT_EN exposes the shift register on state_o.
module lfsr #(
  parameter int               N               = 31,
  parameter logic [N-1:0]     TAPS            = 'h11,
  parameter logic [N-1:0]     START_VALUE     = 1,
  parameter bit               VARIABLE_CONFIG = 1'b0
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          load_config_i,
  input  logic [N-1:0]  taps_i,
  input  logic [N-1:0]  start_value_i,
`ifdef LFSR_STATE_OUT_EN
  output logic [N-1:0]  state_o,
`endif
  output logic          data_o,
  output logic          valid_o
);

  logic [N-1:0] r_state;
  logic [N-1:0] r_taps;
  logic         r_data;
  logic         r_valid;

  logic [N-1:0] w_load_state;
  logic [N-1:0] w_load_taps;
  logic         w_fb;

  // With VARIABLE_CONFIG=0 a load simply restores the elaboration-time defaults.
  assign w_load_state = VARIABLE_CONFIG ? start_value_i : START_VALUE;
  assign w_load_taps  = VARIABLE_CONFIG ? taps_i        : TAPS;
  assign w_fb         = ^(r_state & r_taps);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= START_VALUE;
      r_taps  <= TAPS;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
    end else if (load_config_i) begin
      r_state <= w_load_state;
      r_taps  <= w_load_taps;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= r_state[0];
      r_valid <= 1'b1;
      r_state <= {w_fb, r_state[N-1:1]};
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`ifdef LFSR_STATE_OUT_EN
  assign state_o = r_state;
`endif

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: reference sequences come from the recurrence x(n+N) = XOR taps[i]&x(n+i).
// Honours LFSR_STATE_OUT_EN when the bundle is built with it.
module tb_lfsr;
  localparam int N    = 31;
  localparam int QLEN = 2048;
  localparam logic [N-1:0] DEF_TAPS  = 'h11;
  localparam logic [N-1:0] DEF_START = 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, ld1, d1, v1;
  logic rst2_n, ld2, d2, v2;
  logic rstf_n, ldf, df, vf;
  logic [N-1:0] tap1, sv1, tap2, sv2, tapf, svf;
`ifdef LFSR_STATE_OUT_EN
  logic [N-1:0] st1, st2, stf;
`endif

  lfsr #(.N(N), .TAPS(DEF_TAPS), .START_VALUE(DEF_START), .VARIABLE_CONFIG(1'b1)) u_x1 (
    .clk_i(clk), .reset_ni(rst1_n), .load_config_i(ld1), .taps_i(tap1), .start_value_i(sv1),
`ifdef LFSR_STATE_OUT_EN
    .state_o(st1),
`endif
    .data_o(d1), .valid_o(v1));

  lfsr #(.N(N), .TAPS(DEF_TAPS), .START_VALUE(DEF_START), .VARIABLE_CONFIG(1'b1)) u_x2 (
    .clk_i(clk), .reset_ni(rst2_n), .load_config_i(ld2), .taps_i(tap2), .start_value_i(sv2),
`ifdef LFSR_STATE_OUT_EN
    .state_o(st2),
`endif
    .data_o(d2), .valid_o(v2));

  lfsr #(.N(N)) u_fix (
    .clk_i(clk), .reset_ni(rstf_n), .load_config_i(ldf), .taps_i(tapf), .start_value_i(svf),
`ifdef LFSR_STATE_OUT_EN
    .state_o(stf),
`endif
    .data_o(df), .valid_o(vf));

  // Reference sequence x(0..len-1) built straight from the seed and the recurrence.
  bit mq  [QLEN];
  bit mq2 [QLEN];

  function automatic void gen_seq(input logic [N-1:0] t, input logic [N-1:0] s, input int len);
    bit fb;
    for (int i = 0; i < N; i++) mq[i] = s[i];
    for (int n = 0; n + N < len; n++) begin
      fb = 1'b0;
      for (int i = 0; i < N; i++) fb = fb ^ (t[i] & mq[n+i]);
      mq[n+N] = fb;
    end
  endfunction

  task automatic load1(input logic [N-1:0] t, input logic [N-1:0] s);
    ld1 = 1'b1; tap1 = t; sv1 = s;
    @(negedge clk);
    ld1 = 1'b0;
    tap1 = N'($urandom); sv1 = N'($urandom);
  endtask

  task automatic test_reset();
    rst1_n = 1'b0; rst2_n = 1'b0; rstf_n = 1'b0;
    ld1 = 1'b0; ld2 = 1'b0; ldf = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0 || df !== 1'b0 || vf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got d1=%b v1=%b df=%b vf=%b exp all 0", d1, v1, df, vf);
    end
`ifdef LFSR_STATE_OUT_EN
    n_checks++;
    if (st1 !== DEF_START || stf !== DEF_START) begin
      n_fail++;
      $display("FAIL reset_state got %h/%h exp %h", st1, stf, DEF_START);
    end
`endif
    rstf_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    gen_seq(DEF_TAPS, DEF_START, 64);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (df !== mq[k-1] || vf !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_seq k=%0d got d=%b v=%b exp d=%b v=1", k, df, vf, mq[k-1]);
      end
    end
  endtask

  task automatic test_x1_sequence();
    bit lit;
    gen_seq(31'b1001, 31'd1, 70);
    load1(31'b1001, 31'd1);
    n_checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL x1_load_cycle got d=%b v=%b exp 0 0", d1, v1);
    end
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== mq[k-1] || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL x1_seq x(%0d) got d=%b v=%b exp d=%b v=1", k-1, d1, v1, mq[k-1]);
      end
      if (k-1 <= 59 || k-1 == 62) begin
        lit = (k-1 == 0) || (k-1 == 31) || (k-1 == 59) || (k-1 == 62);
        n_checks++;
        if (d1 !== lit) begin
          n_fail++;
          $display("FAIL x1_known x(%0d) got %b exp %b", k-1, d1, lit);
        end
      end
    end
  endtask

  task automatic test_x2_sequence();
    bit lit;
    gen_seq(31'b1111, 31'd1, 70);
    load1(31'b1111, 31'd1);
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      lit = (k-1 == 0) || (k-1 == 31) || (k-1 >= 59);
      n_checks++;
      if (d1 !== lit || d1 !== mq[k-1]) begin
        n_fail++;
        $display("FAIL x2_seq x(%0d) got %b exp %b (model %b)", k-1, d1, lit, mq[k-1]);
      end
    end
  endtask

  task automatic test_gold();
    int nc = 1600;
    gen_seq(31'b1001, 31'd1, nc + 300);
    mq2 = mq;
    gen_seq(31'b1111, 31'h2, nc + 300);
    ld1 = 1'b1; tap1 = 31'b1001; sv1 = 31'd1;
    ld2 = 1'b1; tap2 = 31'b1111; sv2 = 31'h2;
    @(negedge clk);
    ld1 = 1'b0; ld2 = 1'b0;
    for (int k = 1; k <= nc + 288; k++) begin
      @(negedge clk);
      if (k-1 >= nc) begin
        n_checks++;
        if ((d1 ^ d2) !== (mq2[k-1] ^ mq[k-1]) || v1 !== 1'b1 || v2 !== 1'b1) begin
          n_fail++;
          $display("FAIL gold c(%0d) got %b exp %b", k-1-nc, d1 ^ d2, mq2[k-1] ^ mq[k-1]);
        end
      end
    end
  endtask

  task automatic test_random_config();
    logic [N-1:0] t, s;
    int len;
    for (int it = 0; it < 4; it++) begin
      t = N'($urandom); s = N'($urandom);
      len = $urandom_range(90, 30);
      gen_seq(t, s, len + 1);
      load1(t, s);
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        n_checks++;
        if (d1 !== mq[k-1] || v1 !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_seq it=%0d x(%0d) got %b exp %b taps=%h seed=%h", it, k-1, d1, mq[k-1], t, s);
        end
      end
    end
  endtask

  task automatic test_reload();
    logic [N-1:0] t, s;
    t = N'($urandom) | 31'h1; s = N'($urandom) | 31'h1;
    gen_seq(t, s, 160);
    load1(t, s);
    repeat (100) @(negedge clk);
    n_checks++;
    if (d1 !== mq[99]) begin
      n_fail++;
      $display("FAIL reload_pre x(99) got %b exp %b", d1, mq[99]);
    end
    load1(t, s);
    n_checks++;
    if (v1 !== 1'b0 || d1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_cycle got d=%b v=%b exp 0 0", d1, v1);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== mq[k-1] || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL reload_restart x(%0d) got %b exp %b", k-1, d1, mq[k-1]);
      end
    end
  endtask

  task automatic test_load_held();
    logic [N-1:0] t, s;
    ld1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      t = N'($urandom); s = N'($urandom);
      tap1 = t; sv1 = s;
      @(negedge clk);
      n_checks++;
      if (v1 !== 1'b0 || d1 !== 1'b0) begin
        n_fail++;
        $display("FAIL load_held c=%0d got d=%b v=%b exp 0 0", c, d1, v1);
      end
`ifdef LFSR_STATE_OUT_EN
      n_checks++;
      if (st1 !== s) begin
        n_fail++;
        $display("FAIL load_held_state c=%0d got %h exp %h", c, st1, s);
      end
`endif
    end
    ld1 = 1'b0;
    gen_seq(t, s, 40);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== mq[k-1]) begin
        n_fail++;
        $display("FAIL load_held_seq x(%0d) got %b exp %b", k-1, d1, mq[k-1]);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    gen_seq(31'b1111, 31'h5a5a5, 30);
    load1(31'b1111, 31'h5a5a5);
    repeat (20) @(negedge clk);
    #2 rst1_n = 1'b0;
    #1;
    n_checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got d=%b v=%b exp 0 0", d1, v1);
    end
`ifdef LFSR_STATE_OUT_EN
    n_checks++;
    if (st1 !== DEF_START) begin
      n_fail++;
      $display("FAIL async_reset_state got %h exp %h", st1, DEF_START);
    end
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frozen got d=%b v=%b exp 0 0", d1, v1);
    end
    rst1_n = 1'b1;
    gen_seq(DEF_TAPS, DEF_START, 40);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== mq[k-1] || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset_seq x(%0d) got %b exp %b", k-1, d1, mq[k-1]);
      end
    end
  endtask

  task automatic test_reset_with_load();
    logic [N-1:0] t, s;
    t = N'($urandom) | 31'h1; s = N'($urandom) | 31'h1;
    rst1_n = 1'b0;
    repeat (2) @(negedge clk);
    ld1 = 1'b1; tap1 = t; sv1 = s; rst1_n = 1'b1;
    @(negedge clk);
    ld1 = 1'b0;
    n_checks++;
    if (v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load_cycle got v=%b exp 0", v1);
    end
    gen_seq(t, s, 40);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== mq[k-1]) begin
        n_fail++;
        $display("FAIL reset_load_seq x(%0d) got %b exp %b", k-1, d1, mq[k-1]);
      end
    end
  endtask

  task automatic test_degenerate();
    logic [N-1:0] s;
    load1(N'($urandom), '0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== 1'b0 || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_seed k=%0d got d=%b v=%b exp 0 1", k, d1, v1);
      end
    end
    s = N'($urandom);
    load1('0, s);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      n_checks++;
      if (d1 !== ((k-1 < N) ? s[k-1] : 1'b0)) begin
        n_fail++;
        $display("FAIL zero_taps x(%0d) got %b exp %b", k-1, d1, (k-1 < N) ? s[k-1] : 1'b0);
      end
    end
  endtask

  task automatic test_fixed_config();
    gen_seq(DEF_TAPS, DEF_START, 90);
    for (int it = 0; it < 3; it++) begin
      ldf = 1'b1; tapf = N'($urandom); svf = N'($urandom);
      @(negedge clk);
      ldf = 1'b0; tapf = N'($urandom); svf = N'($urandom);
      n_checks++;
      if (vf !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_load_cycle it=%0d got v=%b exp 0", it, vf);
      end
      for (int k = 1; k <= 80; k++) begin
        @(negedge clk);
        n_checks++;
        if (df !== mq[k-1] || vf !== 1'b1) begin
          n_fail++;
          $display("FAIL fixed_seq it=%0d x(%0d) got %b exp %b", it, k-1, df, mq[k-1]);
        end
      end
    end
  endtask

  initial begin
    tap1 = '0; sv1 = '0; tap2 = '0; sv2 = '0; tapf = '0; svf = '0;
    test_reset();
    test_x1_sequence();
    test_x2_sequence();
    test_gold();
    test_random_config();
    test_reload();
    test_load_held();
    test_async_reset_mid();
    test_reset_with_load();
    test_degenerate();
    test_fixed_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
